draw_line_engine: RTL

- Parametrised, handshaked successor to the existing 8-bit line rasteriser. Draws lines in all eight octants using integer Bresenham.
- Latches both endpoints on a start command and streams one pixel coordinate per accepted beat over a valid/ready interface.
- Reports busy/done status and supports abort.
- Sits between the command decoder and the framebuffer write port of the graphics pipeline.

---
 rtl/draw_pkg.sv | 22 ++
 rtl/line_step.sv | 51 +++++
 rtl/draw_line_engine.sv | 136 +++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared types and helpers for the line rasteriser.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package draw_pkg;

  // Line engine control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Default width of one unsigned X or Y coordinate
  localparam int DEF_COORD_W = 8;

  // Distance between two unsigned coordinates, zero-extended to 32 bits by the caller
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/line_step.sv
// One Bresenham step: next (x,y) and error term from the current ones.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit the result.
module line_step
  import draw_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int ERR_W   = COORD_W + 2
) (
  input  logic [COORD_W-1:0]       x,
  input  logic [COORD_W-1:0]       y,
  input  logic signed [ERR_W-1:0]  err,
  input  logic signed [ERR_W-1:0]  dx,
  input  logic signed [ERR_W-1:0]  dy,
  input  logic                     sx,   // 1 = step x downwards
  input  logic                     sy,   // 1 = step y downwards
  output logic [COORD_W-1:0]       x_nxt,
  output logic [COORD_W-1:0]       y_nxt,
  output logic signed [ERR_W-1:0]  err_nxt
);

  // The doubled error is carried one bit wider: on shallow lines err can
  // climb to about 1.5*dx after a minor-axis step, and 2*err must not wrap.
  logic signed [ERR_W:0] e2;
  logic signed [ERR_W:0] dx_w;
  logic signed [ERR_W:0] dy_w;
  logic                  step_x;
  logic                  step_y;

  assign e2     = {err, 1'b0};
  assign dx_w   = dx;
  assign dy_w   = dy;
  assign step_x = (e2 >= dy_w);
  assign step_y = (e2 <= dx_w);

  // Apply x and y updates independently, both judged against the same e2
  always_comb begin
    x_nxt   = x;
    y_nxt   = y;
    err_nxt = err;
    if (step_x) begin
      err_nxt = err_nxt + dy;
      x_nxt   = sx ? (x - COORD_W'(1)) : (x + COORD_W'(1));
    end
    if (step_y) begin
      err_nxt = err_nxt + dx;
      y_nxt   = sy ? (y - COORD_W'(1)) : (y + COORD_W'(1));
    end
  end

endmodule

// File: rtl/draw_line_engine.sv
// Rasterises a line between two latched endpoints, one pixel per accepted beat.
// Latency: START accepted at edge N -> first pixel valid after edge N+2; DONE one cycle after the last handshake.
// Backpressure: PIX_READY low holds the current pixel and PIX_LAST stable; ABORT overrides any handshake.
module draw_line_engine
  import draw_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int ERR_W   = COORD_W + 2
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               START,
  input  logic               ABORT,
  input  logic [COORD_W-1:0] X_0,
  input  logic [COORD_W-1:0] Y_0,
  input  logic [COORD_W-1:0] X_1,
  input  logic [COORD_W-1:0] Y_1,
  output logic               BUSY,
  output logic               DONE,
  output logic               PIX_VALID,
  input  logic               PIX_READY,
  output logic [COORD_W-1:0] X_Out,
  output logic [COORD_W-1:0] Y_Out,
  output logic               PIX_LAST
);

  state_t                    state;
  logic [COORD_W-1:0]        x, y;
  logic [COORD_W-1:0]        x_end, y_end;
  logic signed [ERR_W-1:0]   dx, dy, err;
  logic                      sx, sy;

  logic [COORD_W-1:0]        x_nxt, y_nxt;
  logic signed [ERR_W-1:0]   err_nxt;
  logic signed [ERR_W-1:0]   dx_abs, dy_abs;
  logic                      at_end, nxt_at_end;

  // The current pixel is the position register itself
  assign X_Out = x;
  assign Y_Out = y;

  // Span of the line on each axis, evaluated in SETUP from the latched endpoints
  assign dx_abs     = ERR_W'(abs_diff(32'(x), 32'(x_end)));
  assign dy_abs     = ERR_W'(abs_diff(32'(y), 32'(y_end)));
  assign at_end     = (x == x_end) && (y == y_end);
  assign nxt_at_end = (x_nxt == x_end) && (y_nxt == y_end);

  line_step #(
    .COORD_W (COORD_W),
    .ERR_W   (ERR_W)
  ) u_step (
    .x       (x),
    .y       (y),
    .err     (err),
    .dx      (dx),
    .dy      (dy),
    .sx      (sx),
    .sy      (sy),
    .x_nxt   (x_nxt),
    .y_nxt   (y_nxt),
    .err_nxt (err_nxt)
  );

  // Control FSM with registered status and pixel outputs
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      x_end     <= '0;
      y_end     <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PIX_VALID <= 1'b0;
      PIX_LAST  <= 1'b0;
    end else if (ABORT && (state != IDLE)) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PIX_VALID <= 1'b0;
      PIX_LAST  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            x     <= X_0;
            y     <= Y_0;
            x_end <= X_1;
            y_end <= Y_1;
            BUSY  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx    <= dx_abs;
          dy    <= -dy_abs;
          err   <= dx_abs - dy_abs;
          sx    <= !(x_end > x);
          sy    <= !(y_end > y);
          state <= DRAW;
        end
        DRAW: begin
          // First DRAW cycle presents the start point; afterwards advance on each handshake
          if (!PIX_VALID) begin
            PIX_VALID <= 1'b1;
            PIX_LAST  <= at_end;
          end else if (PIX_READY) begin
            if (PIX_LAST) begin
              PIX_VALID <= 1'b0;
              PIX_LAST  <= 1'b0;
              DONE      <= 1'b1;
              state     <= FINISH;
            end else begin
              x        <= x_nxt;
              y        <= y_nxt;
              err      <= err_nxt;
              PIX_LAST <= nxt_at_end;
            end
          end
        end
        FINISH: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
